dmux_ram8: RTL and testbench

DMUX_RAM8 -- requirements
Module: dmux_ram8

---
 rtl/dmux_ram8_if.sv | 22 ++
 rtl/dmux_ram8.sv | 73 +++++++
 tb/tb_dmux_ram8.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/dmux_ram8_if.sv
// Bus bundle for the 8-word demux RAM: write/read port, clear request and status.
interface dmux_ram8_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in;
    logic             load;
    logic [2:0]       address;
    logic             clr;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic [7:0]       written;

    modport master (
        output in, load, address, clr,
        input  out, busy, written
    );

    modport slave (
        input  in, load, address, clr,
        output out, busy, written
    );
endinterface

// File: rtl/dmux_ram8.sv
// Eight-word register file with a 1-to-8 write demux, combinational read and
// an eight-cycle clear sweep that zeroes one word per clock.
module dmux_ram8 #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    dmux_ram8_if.slave  bus
);
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state;
    state_t           state_next;
    logic [2:0]       ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] written_q;
    logic [DEPTH-1:0] load_vec;
    logic             start_sweep;

    // A clear request beats a simultaneous write; writes are only decoded in IDLE.
    always_comb begin
        state_next  = state;
        start_sweep = 1'b0;
        load_vec    = '0;
        case (state)
            IDLE: begin
                if (bus.clr) begin
                    state_next  = CLEAR;
                    start_sweep = 1'b1;
                end else if (bus.load) begin
                    load_vec = DEPTH'(1) << bus.address;
                end
            end
            CLEAR: begin
                if (ptr == 3'd7) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            written_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (start_sweep) begin
                ptr <= '0;
            end else if (state == CLEAR) begin
                mem[ptr]       <= '0;
                written_q[ptr] <= 1'b0;
                ptr            <= ptr + 3'd1;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (load_vec[i]) begin
                    mem[i]       <= bus.in;
                    written_q[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.out     = mem[bus.address];
    assign bus.busy    = (state == CLEAR);
    assign bus.written = written_q;
endmodule

// File: tb/tb_dmux_ram8.sv
// Self-checking bench for dmux_ram8: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_dmux_ram8;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    bit   check_en;

    dmux_ram8_if #(.WIDTH(16)) bus ();

    dmux_ram8 #(.WIDTH(16), .DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] model_mem [8];
    logic [7:0]  model_written;
    int          sweep_left;
    int          idx;

    // Reference: a sweep is a countdown of remaining words, the word cleared is 8 - remaining.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) model_mem[i] = 16'h0000;
            model_written = 8'h00;
            sweep_left    = 0;
        end else if (sweep_left != 0) begin
            idx                = 8 - sweep_left;
            model_mem[idx]     = 16'h0000;
            model_written[idx] = 1'b0;
            sweep_left         = sweep_left - 1;
        end else if (bus.clr) begin
            sweep_left = 8;
        end else if (bus.load) begin
            model_mem[bus.address]     = bus.in;
            model_written[bus.address] = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle: outputs must match the model for the address currently applied.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model_out", {16'h0, bus.out}, {16'h0, model_mem[bus.address]});
            checkOutput("model_busy", {31'h0, bus.busy}, {31'h0, (sweep_left != 0)});
            checkOutput("model_written", {24'h0, bus.written}, {24'h0, model_written});
        end
    end

    task automatic applyStimulus(input logic rst, input logic ld, input logic cl,
                                 input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        #1;
        reset       = rst;
        bus.load    = ld;
        bus.clr     = cl;
        bus.address = addr;
        bus.in      = data;
    endtask

    task automatic idle(input logic [2:0] addr);
        applyStimulus(1'b0, 1'b0, 1'b0, addr, 16'h0000);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        check_en    = 1'b0;
        reset       = 1'b1;
        bus.load    = 1'b0;
        bus.clr     = 1'b0;
        bus.address = 3'd0;
        bus.in      = 16'h0000;

        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000);
        idle(3'd0);
        check_en = 1'b1;

        // Reset state: every word zero, nothing written, idle.
        for (int a = 0; a < 8; a++) begin
            idle(3'(a));
            checkOutput("reset_out", {16'h0, bus.out}, 32'h0);
        end
        checkOutput("reset_written", {24'h0, bus.written}, 32'h00);
        checkOutput("reset_busy", {31'h0, bus.busy}, 32'h0);

        // Writes of a pattern and all-ones.
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd3, 16'hA5A5);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd7, 16'hFFFF);
        idle(3'd3);
        checkOutput("wr_addr3", {16'h0, bus.out}, 32'hA5A5);
        idle(3'd7);
        checkOutput("wr_addr7", {16'h0, bus.out}, 32'hFFFF);
        idle(3'd0);
        checkOutput("wr_addr0", {16'h0, bus.out}, 32'h0000);
        checkOutput("wr_written", {24'h0, bus.written}, 32'h88);

        // Read-during-write returns the old value until the edge.
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd5, 16'h1234);
        #1;
        checkOutput("rdw_before", {16'h0, bus.out}, 32'h0000);
        @(posedge clk);
        #1;
        checkOutput("rdw_after", {16'h0, bus.out}, 32'h1234);

        // Fill with 16'h1111*i then sweep; written bit k clears on the k-th sweep edge.
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 3'(i), 16'(16'h1111 * i));
        idle(3'd6);
        checkOutput("fill_addr6", {16'h0, bus.out}, 32'h6666);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 16'h0000);
        for (int k = 0; k < 8; k++) begin
            idle(3'd7);
            checkOutput("sweep_busy", {31'h0, bus.busy}, 32'h1);
            checkOutput("sweep_written", {24'h0, bus.written}, {24'h0, 8'(8'hFF << k)});
        end
        idle(3'd7);
        checkOutput("sweep_end_busy", {31'h0, bus.busy}, 32'h0);
        checkOutput("sweep_end_written", {24'h0, bus.written}, 32'h00);
        checkOutput("sweep_end_addr7", {16'h0, bus.out}, 32'h0000);

        // Load and repeated clr during a sweep are ignored.
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd2, 16'h5555);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd2, 16'h0000);
        for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b1, 1'b1, 3'd2, 16'hBEEF);
        idle(3'd2);
        checkOutput("ign_busy", {31'h0, bus.busy}, 32'h0);
        checkOutput("ign_addr2", {16'h0, bus.out}, 32'h0000);
        checkOutput("ign_written", {24'h0, bus.written}, 32'h00);

        // Reset aborts a sweep part-way through.
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 3'(i), 16'hFFFF);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 16'h0000);
        for (int k = 0; k < 3; k++) idle(3'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd6, 16'h7777);
        idle(3'd0);
        checkOutput("abort_busy", {31'h0, bus.busy}, 32'h0);
        checkOutput("abort_written", {24'h0, bus.written}, 32'h00);
        for (int a = 0; a < 8; a++) begin
            idle(3'(a));
            checkOutput("abort_out", {16'h0, bus.out}, 32'h0);
        end

        // clr wins over a simultaneous load.
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd4, 16'hDEAD);
        idle(3'd4);
        checkOutput("clr_wins_busy", {31'h0, bus.busy}, 32'h1);
        checkOutput("clr_wins_written", {24'h0, bus.written}, 32'h00);
        checkOutput("clr_wins_out", {16'h0, bus.out}, 32'h0000);
        for (int k = 0; k < 8; k++) idle(3'd4);

        // Randomized traffic, checked against the model every cycle.
        for (int n = 0; n < 400; n++) begin
            logic [15:0] d;
            case ($urandom_range(0, 7))
                0:       d = 16'hFFFF;
                1:       d = 16'h0000;
                default: d = 16'($urandom);
            endcase
            applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)), d);
        end
        idle(3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
